// File: rtl/sdram_resp_if.sv
// -----------------------------------------------------------------------------
// sdram_resp_if
//   Command/data bus between an SDRAM controller (master) and the SDRAM
//   responder model (slave).
//
//   Controller -> device : CKE, nCS, nRAS, nCAS, nRWE, BA[1:0], RA[11:0],
//                          DQMH, DQML, DQ_IN[15:0]
//   Device -> controller : DQ_OUT[15:0], DQ_OE[1:0], ROW_OPEN[3:0],
//                          REF_CNT[15:0], ERR, ERR_CODE[2:0]
// -----------------------------------------------------------------------------
interface sdram_resp_if;
    logic        CKE;
    logic        nCS;
    logic        nRAS;
    logic        nCAS;
    logic        nRWE;
    logic [1:0]  BA;
    logic [11:0] RA;
    logic        DQMH;
    logic        DQML;
    logic [15:0] DQ_IN;
    logic [15:0] DQ_OUT;
    logic [1:0]  DQ_OE;
    logic [3:0]  ROW_OPEN;
    logic [15:0] REF_CNT;
    logic        ERR;
    logic [2:0]  ERR_CODE;

    modport master (
        output CKE, nCS, nRAS, nCAS, nRWE, BA, RA, DQMH, DQML, DQ_IN,
        input  DQ_OUT, DQ_OE, ROW_OPEN, REF_CNT, ERR, ERR_CODE
    );

    modport slave (
        input  CKE, nCS, nRAS, nCAS, nRWE, BA, RA, DQMH, DQML, DQ_IN,
        output DQ_OUT, DQ_OE, ROW_OPEN, REF_CNT, ERR, ERR_CODE
    );
endinterface

// File: rtl/sdram_resp.sv
// -----------------------------------------------------------------------------
// sdram_resp
//   Device-side SDRAM responder. Decodes the controller command bus, tracks
//   the open row of each of the four banks, keeps a 2^MEM_AW x 16 backing
//   store, returns read data CAS_LAT active cycles after RD and flags the
//   first protocol violation since reset.
//
//   Ports:
//     CLK  - clock, everything on posedge
//     RST  - synchronous reset, active-high
//     bus  - sdram_resp_if.slave (command strobes, address, byte masks,
//            write data in; read data, per-byte output enable, per-bank open
//            flags, refresh count, error flag and first error code out)
//
//   Optional build macro SDRAM_REFCHK_EN: adds a free-running refresh
//   interval timer that raises error 6 when REF_MAX clocks pass without an
//   accepted AREF. Without the macro there is no timer and code 6 never
//   occurs.
//
//   Error codes: 1 ACT to open bank, 2 RD/WR to idle bank, 3 AREF with a bank
//   open, 4 unsupported command (MRS/BST), 5 RD/WR inside tRCD, 6 refresh
//   timeout.
// -----------------------------------------------------------------------------
module sdram_resp #(
    parameter int CAS_LAT = 2,
    parameter int MEM_AW  = 10,
    parameter int TRCD    = 2,
    parameter int REF_MAX = 1560
) (
    input logic         CLK,
    input logic         RST,
    sdram_resp_if.slave bus
);

    localparam int TW = $clog2(TRCD + 1) + 1;

    localparam logic [2:0] E_NONE      = 3'd0;
    localparam logic [2:0] E_ACT_OPEN  = 3'd1;
    localparam logic [2:0] E_IDLE_ACC  = 3'd2;
    localparam logic [2:0] E_AREF_OPEN = 3'd3;
    localparam logic [2:0] E_UNSUP     = 3'd4;
    localparam logic [2:0] E_TRCD      = 3'd5;
    localparam logic [2:0] E_REF_TO    = 3'd6;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_AREF,
        CMD_BAD
    } cmd_e;

    logic                cke_q;
    logic                active;
    cmd_e                cmd;
    logic [2:0]          cmd_err;
    logic                exec;
    logic                do_act;
    logic                do_rd;
    logic                do_wr;
    logic                do_pre;
    logic                do_aref;
    logic                ref_timeout;

    logic [3:0]          row_open;
    logic [11:0]         open_row [4];
    logic [TW-1:0]       rcd_cnt  [4];
    logic [15:0]         ref_cnt;
    logic                err;
    logic [2:0]          err_code;

    logic [1:0]          ba;
    logic                bank_open;
    logic [22:0]         full_addr;
    logic [MEM_AW-1:0]   mem_idx;
    logic [15:0]         mem [2**MEM_AW];

    logic [CAS_LAT-1:0]  vld_p;
    logic [15:0]         rd_data_p [CAS_LAT];
    logic [1:0]          dqm_p;
    logic [15:0]         dq_out;
    logic [1:0]          dq_oe;

    logic                unused_bits;

    // A command is only looked at when CKE was high on the previous edge.
    always_ff @(posedge CLK) begin
        if (RST) cke_q <= 1'b1;
        else     cke_q <= bus.CKE;
    end

    assign active = cke_q;

    always_comb begin
        cmd = CMD_NOP;
        if (!bus.nCS) begin
            case ({bus.nRAS, bus.nCAS, bus.nRWE})
                3'b111:  cmd = CMD_NOP;
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_AREF;
                default: cmd = CMD_BAD;
            endcase
        end
    end

    assign ba        = bus.BA;
    assign bank_open = row_open[ba];
    assign full_addr = {ba, open_row[ba], bus.RA[8:0]};
    assign mem_idx   = full_addr[MEM_AW-1:0];

    always_comb begin
        cmd_err = E_NONE;
        case (cmd)
            CMD_ACT:  if (bank_open) cmd_err = E_ACT_OPEN;
            CMD_RD,
            CMD_WR: begin
                if (!bank_open)                    cmd_err = E_IDLE_ACC;
                else if (rcd_cnt[ba] < TW'(TRCD))  cmd_err = E_TRCD;
            end
            CMD_AREF: if (|row_open) cmd_err = E_AREF_OPEN;
            CMD_BAD:  cmd_err = E_UNSUP;
            default:  cmd_err = E_NONE;
        endcase
    end

    // A tRCD violation is reported but the access is still carried out;
    // every other error suppresses the command.
    assign exec    = active && !RST && (cmd_err == E_NONE || cmd_err == E_TRCD);
    assign do_act  = exec && (cmd == CMD_ACT);
    assign do_rd   = exec && (cmd == CMD_RD);
    assign do_wr   = exec && (cmd == CMD_WR);
    assign do_pre  = exec && (cmd == CMD_PRE);
    assign do_aref = exec && (cmd == CMD_AREF);

    // rcd_cnt counts active cycles since ACT (1 on the edge after ACT) and
    // saturates at TRCD, which is also its idle value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            row_open <= '0;
            ref_cnt  <= '0;
            for (int b = 0; b < 4; b++) rcd_cnt[b] <= TW'(TRCD);
        end else if (active) begin
            for (int b = 0; b < 4; b++)
                if (rcd_cnt[b] < TW'(TRCD)) rcd_cnt[b] <= rcd_cnt[b] + TW'(1);
            if (do_act) begin
                row_open[ba] <= 1'b1;
                rcd_cnt[ba]  <= TW'(1);
            end
            if (do_pre) begin
                if (bus.RA[10]) row_open     <= '0;
                else            row_open[ba] <= 1'b0;
            end
            if ((do_rd || do_wr) && bus.RA[10]) row_open[ba] <= 1'b0;
            if (do_aref) ref_cnt <= ref_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_act) open_row[ba] <= bus.RA;
    end

    always_ff @(posedge CLK) begin
        if (do_wr && !bus.DQMH) mem[mem_idx][15:8] <= bus.DQ_IN[15:8];
        if (do_wr && !bus.DQML) mem[mem_idx][7:0]  <= bus.DQ_IN[7:0];
    end

`ifdef SDRAM_REFCHK_EN
    logic [15:0] ref_timer;

    // Counts every clock, suspended or not; the error fires on the edge that
    // brings the timer to REF_MAX, after which it stays there.
    always_ff @(posedge CLK) begin
        if (RST)                             ref_timer <= '0;
        else if (do_aref)                    ref_timer <= '0;
        else if (ref_timer != 16'(REF_MAX))  ref_timer <= ref_timer + 16'd1;
    end

    assign ref_timeout = !do_aref && (ref_timer == 16'(REF_MAX - 1));
`else
    // No refresh supervision in this build; REF_MAX has no effect here.
    assign ref_timeout = (REF_MAX < 0);
`endif

    // First error wins; a command error on the same edge as a timeout is
    // reported in preference to the timeout.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err      <= 1'b0;
            err_code <= E_NONE;
        end else if (!err) begin
            if (active && cmd_err != E_NONE) begin
                err      <= 1'b1;
                err_code <= cmd_err;
            end else if (ref_timeout) begin
                err      <= 1'b1;
                err_code <= E_REF_TO;
            end
        end
    end

    // Read pipe stage p0 is loaded at the RD edge; all stages advance only on
    // active edges so clock suspend stretches the latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p <= '0;
            dqm_p <= 2'b00;
        end else if (active) begin
            vld_p <= {vld_p[CAS_LAT-2:0], do_rd};
            dqm_p <= {bus.DQMH, bus.DQML};
        end
    end

    always_ff @(posedge CLK) begin
        if (active) begin
            rd_data_p[0] <= mem[mem_idx];
            for (int i = 1; i < CAS_LAT; i++) rd_data_p[i] <= rd_data_p[i-1];
        end
    end

    // Output stage: dqm_p holds the mask from the previous active edge, which
    // gives the two-cycle read DQM latency relative to the data cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dq_out <= '0;
            dq_oe  <= 2'b00;
        end else if (active) begin
            if (vld_p[CAS_LAT-1]) begin
                dq_out <= rd_data_p[CAS_LAT-1];
                dq_oe  <= ~dqm_p;
            end else begin
                dq_oe  <= 2'b00;
            end
        end
    end

    assign bus.DQ_OUT   = dq_out;
    assign bus.DQ_OE    = dq_oe;
    assign bus.ROW_OPEN = row_open;
    assign bus.REF_CNT  = ref_cnt;
    assign bus.ERR      = err;
    assign bus.ERR_CODE = err_code;

    // Address bits that never reach the backing store.
    assign unused_bits = ^{bus.RA[11], bus.RA[9], full_addr[22:MEM_AW]};

endmodule
